// File: rtl/gci_device_responder.sv
// GCI-bus far-end device: announces its address-space size after reset, serves a
// small word register file to core reads/writes and forwards local interrupts.
module gci_device_responder #(
    parameter logic [31:0] P_GCI_SIZE   = 32'h0001_0000,
    parameter int unsigned P_REG_NUM    = 16,
    parameter int unsigned P_INIT_DELAY = 32
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iGCI_REQ,
    output logic        oGCI_BUSY,
    input  logic        iGCI_RW,
    input  logic [31:0] iGCI_ADDR,
    input  logic [31:0] iGCI_DATA,
    output logic        oGCI_REQ,
    input  logic        iGCI_BUSY,
    output logic [31:0] oGCI_DATA,
    output logic        oGCI_IRQ_REQ,
    output logic [5:0]  oGCI_IRQ_NUM,
    input  logic        iGCI_IRQ_ACK,
    input  logic        iIRQ_EVENT,
    input  logic [5:0]  iIRQ_NUM
);
    localparam int unsigned IDX_W = $clog2(P_REG_NUM);

    typedef enum logic [1:0] {
        S_INIT_WAIT,
        S_INIT_SEND,
        S_IDLE,
        S_READ_RESP
    } state_e;

    state_e            state_q;
    logic [31:0]       init_cnt_q;
    logic [31:0]       init_cnt_d;
    logic              busy_q;
    logic              ret_req_q;
    logic [31:0]       ret_data_q;
    logic [31:0]       regs_q [P_REG_NUM];
    logic              irq_req_q;
    logic [5:0]        irq_num_q;
    logic              irq_ovf_q;

    logic [IDX_W-1:0]  idx;
    logic              accept_wr;
    logic [31:0]       rd_data;
    logic              unused_addr;

    // Upper address bits are ignored, so the register file aliases across the space.
    assign idx         = iGCI_ADDR[IDX_W+1:2];
    assign unused_addr = ^{iGCI_ADDR[31:IDX_W+2], iGCI_ADDR[1:0]};
    assign accept_wr   = (state_q == S_IDLE) && iGCI_REQ && iGCI_RW;
    assign init_cnt_d  = init_cnt_q + 32'd1;

    always_comb begin
        // NOTE: rd_data gets a default before any condition so no path infers a latch.
        rd_data = regs_q[idx];
        if (idx == '0) begin
            rd_data = {30'h0, irq_ovf_q, irq_req_q};
        end
    end

    // Bus-side FSM; every output is a register.  Each return pulse is followed by a
    // cleanup cycle, so BUSY drops one cycle after the pulse.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q    <= S_INIT_WAIT;
            init_cnt_q <= '0;
            busy_q     <= 1'b1;
            ret_req_q  <= 1'b0;
            ret_data_q <= '0;
        end else begin
            case (state_q)
                S_INIT_WAIT: begin
                    if (init_cnt_d >= P_INIT_DELAY) begin
                        init_cnt_q <= '0;
                        state_q    <= S_INIT_SEND;
                    end else begin
                        init_cnt_q <= init_cnt_d;
                    end
                end
                S_INIT_SEND, S_READ_RESP: begin
                    if (ret_req_q) begin
                        ret_req_q  <= 1'b0;
                        ret_data_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (!iGCI_BUSY) begin
                        ret_req_q <= 1'b1;
                        if (state_q == S_INIT_SEND) begin
                            ret_data_q <= P_GCI_SIZE;
                        end
                    end
                end
                S_IDLE: begin
                    if (iGCI_REQ && !iGCI_RW) begin
                        ret_data_q <= rd_data;
                        busy_q     <= 1'b1;
                        state_q    <= S_READ_RESP;
                    end
                end
                default: begin
                    state_q <= S_INIT_WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            // NOTE: the register file has a defined reset value, so every word is reset here.
            for (int i = 0; i < int'(P_REG_NUM); i++) begin
                regs_q[i] <= '0;
            end
        end else if (accept_wr && (idx != '0)) begin
            regs_q[idx] <= iGCI_DATA;
        end
    end

    // Interrupt channel; a new event while one is pending (even in the ACK cycle)
    // is dropped and recorded as overflow, which wins over a same-cycle clear.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            irq_req_q <= 1'b0;
            irq_num_q <= '0;
            irq_ovf_q <= 1'b0;
        end else begin
            if (accept_wr && (idx == '0) && iGCI_DATA[1]) begin
                irq_ovf_q <= 1'b0;
            end
            if (irq_req_q) begin
                if (iIRQ_EVENT) begin
                    irq_ovf_q <= 1'b1;
                end
                if (iGCI_IRQ_ACK) begin
                    irq_req_q <= 1'b0;
                end
            end else if (iIRQ_EVENT) begin
                irq_req_q <= 1'b1;
                irq_num_q <= iIRQ_NUM;
            end
        end
    end

    assign oGCI_BUSY    = busy_q;
    assign oGCI_REQ     = ret_req_q;
    assign oGCI_DATA    = ret_data_q;
    assign oGCI_IRQ_REQ = irq_req_q;
    assign oGCI_IRQ_NUM = irq_num_q;

endmodule

// File: tb/tb_gci_device_responder.sv
// Self-checking bench for gci_device_responder: directed scenarios plus random
// bus/interrupt traffic compared against a transaction-level model.
module tb_gci_device_responder;
    localparam logic [31:0] GCI_SIZE   = 32'h0001_0000;
    localparam int          REG_NUM    = 16;
    localparam int          INIT_DELAY = 32;
    localparam int          IDX_W      = $clog2(REG_NUM);

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iGCI_REQ = 1'b0;
    logic        oGCI_BUSY;
    logic        iGCI_RW = 1'b0;
    logic [31:0] iGCI_ADDR = '0;
    logic [31:0] iGCI_DATA = '0;
    logic        oGCI_REQ;
    logic        iGCI_BUSY = 1'b0;
    logic [31:0] oGCI_DATA;
    logic        oGCI_IRQ_REQ;
    logic [5:0]  oGCI_IRQ_NUM;
    logic        iGCI_IRQ_ACK = 1'b0;
    logic        iIRQ_EVENT = 1'b0;
    logic [5:0]  iIRQ_NUM = '0;

    gci_device_responder #(
        .P_GCI_SIZE  (GCI_SIZE),
        .P_REG_NUM   (REG_NUM),
        .P_INIT_DELAY(INIT_DELAY)
    ) dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iGCI_REQ    (iGCI_REQ),
        .oGCI_BUSY   (oGCI_BUSY),
        .iGCI_RW     (iGCI_RW),
        .iGCI_ADDR   (iGCI_ADDR),
        .iGCI_DATA   (iGCI_DATA),
        .oGCI_REQ    (oGCI_REQ),
        .iGCI_BUSY   (iGCI_BUSY),
        .oGCI_DATA   (oGCI_DATA),
        .oGCI_IRQ_REQ(oGCI_IRQ_REQ),
        .oGCI_IRQ_NUM(oGCI_IRQ_NUM),
        .iGCI_IRQ_ACK(iGCI_IRQ_ACK),
        .iIRQ_EVENT  (iIRQ_EVENT),
        .iIRQ_NUM    (iIRQ_NUM)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register contents and interrupt state, updated per transaction.
    logic [31:0] regs_m [REG_NUM];
    bit          pend_m;
    bit          ovf_m;
    logic [5:0]  num_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [IDX_W-1:0] i;
        i = addr[IDX_W+1:2];
        if (i == '0) return {30'h0, ovf_m, pend_m};
        return regs_m[i];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < REG_NUM; i++) regs_m[i] = '0;
        pend_m = 0;
        ovf_m  = 0;
        num_m  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(oGCI_BUSY),    32'd1);
        check({tag, "_req"},     32'(oGCI_REQ),     32'd0);
        check({tag, "_data"},    oGCI_DATA,         32'd0);
        check({tag, "_irq_req"}, 32'(oGCI_IRQ_REQ), 32'd0);
        check({tag, "_irq_num"}, 32'(oGCI_IRQ_NUM), 32'd0);
    endtask

    // Called on the negedge of reset release; expects exactly one init pulse.
    task automatic init_seq(input int busy_hold);
        int first = 0;
        int pulses = 0;
        bit busy_early = 0;
        iGCI_BUSY = (busy_hold > 0);
        for (int c = 1; c <= INIT_DELAY + busy_hold + 8; c++) begin
            @(negedge iCLOCK);
            if (oGCI_REQ) begin
                pulses++;
                if (first == 0) begin
                    first = c;
                    check("init_data", oGCI_DATA, GCI_SIZE);
                end
            end else if (first == 0 && !oGCI_BUSY) begin
                busy_early = 1;
            end
            if (first != 0 && c == first + 1) begin
                check("init_busy_fall", 32'(oGCI_BUSY), 32'd0);
                check("init_data_clear", oGCI_DATA, 32'd0);
            end
            if (c == INIT_DELAY + busy_hold) iGCI_BUSY = 1'b0;
        end
        check("init_cycle", first, INIT_DELAY + busy_hold + 1);
        check("init_pulses", pulses, 32'd1);
        check("init_busy_early", 32'(busy_early), 32'd0);
    endtask

    task automatic do_reset(input int busy_hold);
        @(negedge iCLOCK);
        inRESET = 1'b0;
        iGCI_REQ = 1'b0;
        iIRQ_EVENT = 1'b0;
        iGCI_IRQ_ACK = 1'b0;
        iGCI_BUSY = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (3) begin
            @(negedge iCLOCK);
            check("rst_no_req", 32'(oGCI_REQ), 32'd0);
        end
        inRESET = 1'b1;
        model_clear();
        init_seq(busy_hold);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        logic [IDX_W-1:0] i;
        check("wr_ready", 32'(oGCI_BUSY), 32'd0);
        iGCI_REQ = 1'b1;
        iGCI_RW = 1'b1;
        iGCI_ADDR = addr;
        iGCI_DATA = data;
        @(negedge iCLOCK);
        iGCI_REQ = 1'b0;
        i = addr[IDX_W+1:2];
        if (i == '0) begin
            if (data[1]) ovf_m = 0;
        end else begin
            regs_m[i] = data;
        end
        check("wr_stays_idle", 32'(oGCI_BUSY), 32'd0);
    endtask

    // Read with iGCI_BUSY held for 'stall' cycles; optionally a write is attempted mid-stall.
    task automatic bus_read(input logic [31:0] addr, input int stall, input bit intrude,
                            input logic [31:0] intr_addr);
        logic [31:0] exp;
        logic [31:0] hold;
        int          pulse_at = 0;
        bit          stable_ok = 1;
        bit          busy_ok = 1;
        exp = model_read(addr);
        check("rd_ready", 32'(oGCI_BUSY), 32'd0);
        iGCI_REQ = 1'b1;
        iGCI_RW = 1'b0;
        iGCI_ADDR = addr;
        iGCI_BUSY = (stall > 0);
        hold = '0;
        for (int c = 1; c <= stall + 6 && pulse_at == 0; c++) begin
            @(negedge iCLOCK);
            if (c == 1) hold = oGCI_DATA;
            if (oGCI_REQ) begin
                pulse_at = c;
                check("rd_data", oGCI_DATA, exp);
            end else begin
                if (!oGCI_BUSY) busy_ok = 0;
                if (oGCI_DATA !== hold) stable_ok = 0;
            end
            if (intrude && c == 1) begin
                iGCI_REQ = 1'b1;
                iGCI_RW = 1'b1;
                iGCI_ADDR = intr_addr;
                iGCI_DATA = $urandom;
            end else begin
                iGCI_REQ = 1'b0;
            end
            if (c == stall) iGCI_BUSY = 1'b0;
        end
        iGCI_REQ = 1'b0;
        check("rd_latency", pulse_at, (stall == 0) ? 2 : stall + 1);
        check("rd_busy_held", 32'(busy_ok), 32'd1);
        check("rd_data_stable", 32'(stable_ok), 32'd1);
        @(negedge iCLOCK);
        check("rd_req_single", 32'(oGCI_REQ), 32'd0);
        check("rd_data_clear", oGCI_DATA, 32'd0);
        check("rd_busy_fall", 32'(oGCI_BUSY), 32'd0);
    endtask

    task automatic irq_cycle(input bit ev, input logic [5:0] n, input bit ack);
        iIRQ_EVENT = ev;
        iIRQ_NUM = n;
        iGCI_IRQ_ACK = ack;
        @(negedge iCLOCK);
        iIRQ_EVENT = 1'b0;
        iGCI_IRQ_ACK = 1'b0;
        if (pend_m) begin
            if (ev) ovf_m = 1;
            if (ack) pend_m = 0;
        end else if (ev) begin
            pend_m = 1;
            num_m = n;
        end
        check("irq_req", 32'(oGCI_IRQ_REQ), 32'(pend_m));
        if (pend_m) check("irq_num", 32'(oGCI_IRQ_NUM), 32'(num_m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(negedge iCLOCK);
        check_reset_outputs("por");
        inRESET = 1'b1;
        init_seq(0);

        // Init with the core stalling the return channel.
        do_reset(10);

        // Write/read, aliasing, stalled read with an ignored second request.
        bus_write(32'h0000_000C, 32'hDEAD_BEEF);
        bus_read(32'h0000_000C, 0, 0, '0);
        bus_read(32'h0000_004C, 0, 0, '0);
        bus_read(32'h0000_000C, 5, 1, 32'h0000_0010);
        bus_read(32'h0000_0010, 0, 0, '0);

        // Interrupt handshake and overflow.
        irq_cycle(1, 6'h05, 0);
        repeat (3) irq_cycle(0, 6'h00, 0);
        irq_cycle(1, 6'h07, 0);
        bus_read(32'h0000_0000, 0, 0, '0);
        check("status_pend_ovf", model_read(32'h0), 32'h3);
        bus_write(32'h0000_0000, 32'h0000_0002);
        irq_cycle(0, 6'h00, 1);
        bus_read(32'h0000_0000, 0, 0, '0);

        // Event in the ACK cycle is dropped; the next one gets through after a low cycle.
        irq_cycle(1, 6'h09, 0);
        irq_cycle(1, 6'h0A, 1);
        irq_cycle(1, 6'h0B, 0);
        irq_cycle(0, 6'h00, 1);
        bus_write(32'h0000_0000, 32'h0000_0002);
        bus_read(32'h0000_0000, 0, 0, '0);

        // Random traffic.
        for (int k = 0; k < 250; k++) begin
            int op;
            int st;
            op = $urandom_range(0, 3);
            st = $urandom_range(0, 3);
            case (op)
                0: bus_write($urandom, $urandom);
                1: bus_read($urandom, st, (st > 0) && ($urandom_range(0, 1) == 1), $urandom);
                default: irq_cycle($urandom_range(0, 2) == 0, 6'($urandom), $urandom_range(0, 2) == 0);
            endcase
        end

        // Reset in the middle of a stalled read.
        bus_write(32'h0000_0014, 32'h1234_5678);
        if (!pend_m) irq_cycle(1, 6'h03, 0);
        iGCI_REQ = 1'b1;
        iGCI_RW = 1'b0;
        iGCI_ADDR = 32'h0000_0014;
        iGCI_BUSY = 1'b1;
        @(negedge iCLOCK);
        iGCI_REQ = 1'b0;
        @(negedge iCLOCK);
        check("mid_stall_busy", 32'(oGCI_BUSY), 32'd1);
        do_reset(0);
        bus_read(32'h0000_0014, 0, 0, '0);
        bus_read(32'h0000_0000, 0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
